ntt_butterfly_pipe: RTL and testbench

// Streaming, fully pipelined radix-2 NTT butterfly with a runtime-loadable twiddle RAM.

---
 rtl/ntt_butterfly_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_ntt_butterfly_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe
// Streaming radix-2 NTT butterfly with a runtime-loadable twiddle RAM.
// Each sample selects its own butterfly form:
//   mode=0 Cooley-Tukey : p = y*w;  x' = x+p;  y' = x-p       (all mod Q)
//   mode=1 Gentleman-Sande: x' = x+y;  y' = (x-y)*w           (all mod Q)
// Latency is MULT_LAT+2 for both forms, so mixed-mode streams stay in order.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, x_in, y_in, mode   input sample (operands must be < Q)
//   tw_clr               restart the twiddle index at 0
//   tw_we, tw_waddr, tw_wdata    twiddle RAM write port
//   out_valid, x_out, y_out      registered result
module ntt_butterfly_pipe #(
  parameter int              W        = 28,
  parameter longint unsigned Q        = 64'd268369921,
  parameter int              NTW      = 32,
  parameter int              MULT_LAT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [W-1:0]           x_in,
  input  logic [W-1:0]           y_in,
  input  logic                   mode,
  input  logic                   tw_clr,
  input  logic                   tw_we,
  input  logic [$clog2(NTW)-1:0] tw_waddr,
  input  logic [W-1:0]           tw_wdata,
  output logic                   out_valid,
  output logic [W-1:0]           x_out,
  output logic [W-1:0]           y_out
);

  localparam int IW = $clog2(NTW);
  // Barrett reduction constants: K is the bit length of Q, so 2**(K-1) < Q < 2**K.
  localparam int              K   = $clog2(Q);
  localparam int              PW  = 2 * W + 2;
  localparam logic [W-1:0]    Q_W  = W'(Q);
  localparam logic [W:0]      Q_W1 = (W + 1)'(Q);
  localparam logic [PW-1:0]   Q_P  = PW'(Q);
  localparam logic [PW-1:0]   MU   = (PW'(1'b1) << (2 * K)) / Q_P;

  // (a + b) mod Q for a, b < Q, using one conditional subtract.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_W1) begin
      s = s - Q_W1;
    end else begin
      s = s;
    end
    return s[W-1:0];
  endfunction

  // (a - b) mod Q for a, b < Q; the W-bit wrap of a-b+Q is exact because the result is < Q.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    if (a < b) begin
      d = a - b + Q_W;
    end else begin
      d = a - b;
    end
    return d;
  endfunction

  // Barrett reduction of a product p < Q*Q. The quotient estimate is at most
  // two short, so the remainder is < 3Q and needs at most two corrections.
  function automatic logic [W-1:0] mod_reduce(input logic [2*W-1:0] p);
    logic [PW-1:0] q_est;
    logic [PW-1:0] r;
    q_est = ((PW'(p) >> (K - 1)) * MU) >> (K + 1);
    r     = PW'(p) - q_est * Q_P;
    if (r >= Q_P) begin
      r = r - Q_P;
    end else begin
      r = r;
    end
    if (r >= Q_P) begin
      r = r - Q_P;
    end else begin
      r = r;
    end
    return r[W-1:0];
  endfunction

  // Twiddle storage and index
  logic [W-1:0]  ram_r [NTW];
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_sel_s;
  logic [IW-1:0] idx_nxt_s;

  // Stage 1: captured sample plus its twiddle
  logic [W-1:0]  x1_r;
  logic [W-1:0]  y1_r;
  logic [W-1:0]  w1_r;
  logic          mode1_r;
  logic          vld1_r;

  logic [W-1:0]  sum1_s;
  logic [W-1:0]  diff1_s;
  logic [W-1:0]  mul_a_s;
  logic [W-1:0]  side1_s;

  // Multiplier pipeline (product stage + MULT_LAT-1 reduced stages)
  logic [2*W-1:0] prod_r;
  logic [W-1:0]   red_pipe_r [MULT_LAT-1];

  // Side-band delay line aligned with the multiplier; index 0 is the youngest entry
  logic [W-1:0]        side_pipe_r [MULT_LAT];
  logic [MULT_LAT-1:0] mode_pipe_r;
  logic [MULT_LAT-1:0] vld_pipe_r;

  logic [W-1:0]  p_end_s;
  logic [W-1:0]  side_end_s;
  logic          mode_end_s;
  logic          vld_end_s;
  logic [W-1:0]  x_nxt_s;
  logic [W-1:0]  y_nxt_s;

  // Twiddle index selection: tw_clr forces index 0 for a sample in the same cycle.
  always_comb begin
    idx_sel_s = idx_r;
    idx_nxt_s = idx_r;
    if (tw_clr) begin
      idx_sel_s = {IW{1'b0}};
    end else begin
      idx_sel_s = idx_r;
    end
    if (in_valid) begin
      if (idx_sel_s == IW'(NTW - 1)) begin
        idx_nxt_s = {IW{1'b0}};
      end else begin
        idx_nxt_s = idx_sel_s + IW'(1);
      end
    end else if (tw_clr) begin
      idx_nxt_s = {IW{1'b0}};
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Twiddle index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IW{1'b0}};
    end else begin
      idx_r <= idx_nxt_s;
    end
  end

  // Twiddle RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (tw_we) begin
      ram_r[tw_waddr] <= tw_wdata;
    end
  end

  // Stage-1 data capture; the RAM read sees the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    x1_r    <= x_in;
    y1_r    <= y_in;
    mode1_r <= mode;
    w1_r    <= ram_r[idx_sel_s];
  end

  // Stage-1 valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_r <= 1'b0;
    end else begin
      vld1_r <= in_valid;
    end
  end

  // GS pre-processing: the multiplier takes x-y and the sum bypasses it; CT multiplies y and bypasses x.
  always_comb begin
    sum1_s  = mod_add(x1_r, y1_r);
    diff1_s = mod_sub(x1_r, y1_r);
    mul_a_s = y1_r;
    side1_s = x1_r;
    if (mode1_r) begin
      mul_a_s = diff1_s;
      side1_s = sum1_s;
    end else begin
      mul_a_s = y1_r;
      side1_s = x1_r;
    end
  end

  // Modular multiplier: raw product, reduction, then plain delay stages up to MULT_LAT.
  always_ff @(posedge clk) begin
    prod_r        <= (2 * W)'(mul_a_s) * (2 * W)'(w1_r);
    red_pipe_r[0] <= mod_reduce(prod_r);
    for (int i = 1; i < MULT_LAT - 1; i++) begin
      red_pipe_r[i] <= red_pipe_r[i-1];
    end
  end

  // Bypass-operand and mode delay line matching the multiplier depth.
  always_ff @(posedge clk) begin
    side_pipe_r[0] <= side1_s;
    for (int i = 1; i < MULT_LAT; i++) begin
      side_pipe_r[i] <= side_pipe_r[i-1];
    end
    mode_pipe_r <= {mode_pipe_r[MULT_LAT-2:0], mode1_r};
  end

  // Valid delay line; cleared on reset so in-flight samples never emerge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_r <= {MULT_LAT{1'b0}};
    end else begin
      vld_pipe_r <= {vld_pipe_r[MULT_LAT-2:0], vld1_r};
    end
  end

  // Post-processing: CT finishes with add/sub of p; GS outputs the bypassed sum and the product.
  always_comb begin
    p_end_s    = red_pipe_r[MULT_LAT-2];
    side_end_s = side_pipe_r[MULT_LAT-1];
    mode_end_s = mode_pipe_r[MULT_LAT-1];
    vld_end_s  = vld_pipe_r[MULT_LAT-1];
    x_nxt_s    = side_end_s;
    y_nxt_s    = p_end_s;
    if (mode_end_s) begin
      x_nxt_s = side_end_s;
      y_nxt_s = p_end_s;
    end else begin
      x_nxt_s = mod_add(side_end_s, p_end_s);
      y_nxt_s = mod_sub(side_end_s, p_end_s);
    end
  end

  // Output register; data holds its last value when no sample emerges.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x_out     <= {W{1'b0}};
      y_out     <= {W{1'b0}};
    end else begin
      out_valid <= vld_end_s;
      if (vld_end_s) begin
        x_out <= x_nxt_s;
        y_out <= y_nxt_s;
      end else begin
        x_out <= x_out;
        y_out <= y_out;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Directed bench for ntt_butterfly_pipe with a queue of expected results
// carrying the cycle on which each result is due.
module tb_ntt_butterfly_pipe;

  localparam int              W        = 28;
  localparam int              NTW      = 32;
  localparam int              MULT_LAT = 5;
  localparam int              L        = MULT_LAT + 2;
  localparam longint unsigned QM       = 64'd268369921;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic          mode;
  logic          tw_clr;
  logic          tw_we;
  logic [4:0]    tw_waddr;
  logic [W-1:0]  tw_wdata;
  logic          out_valid;
  logic [W-1:0]  x_out;
  logic [W-1:0]  y_out;

  ntt_butterfly_pipe #(
    .W(W), .Q(QM), .NTW(NTW), .MULT_LAT(MULT_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .mode(mode), .tw_clr(tw_clr), .tw_we(tw_we), .tw_waddr(tw_waddr),
    .tw_wdata(tw_wdata), .out_valid(out_valid), .x_out(x_out), .y_out(y_out)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc;
  int           n_pass;
  int           n_total;
  int           tb_idx;
  logic [W-1:0] mirror [NTW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected entry on its due cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq({e.tag, "_lat"}, cyc, e.due);
        check_eq({e.tag, "_x"}, {4'd0, x_out}, {4'd0, e.ex});
        check_eq({e.tag, "_y"}, {4'd0, y_out}, {4'd0, e.ey});
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check_eq({exp_q[0].tag, "_missing"}, {31'd0, out_valid}, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  function automatic void model(input longint unsigned x, input longint unsigned y,
                                input longint unsigned w, input bit m,
                                output longint unsigned ex, output longint unsigned ey);
    longint unsigned p;
    longint unsigned d;
    if (!m) begin
      p  = (y * w) % QM;
      ex = (x + p) % QM;
      ey = (x + QM - p) % QM;
    end else begin
      ex = (x + y) % QM;
      d  = (x + QM - y) % QM;
      ey = (d * w) % QM;
    end
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0;
    tw_clr   = 1'b0;
    tw_we    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ram_write(input int a, input logic [W-1:0] d);
    tw_we    = 1'b1;
    tw_waddr = 5'(a);
    tw_wdata = d;
    @(posedge clk);
    #1;
    mirror[a] = d;
    tw_we     = 1'b0;
  endtask

  // Presents one sample for one cycle; tw_we may already be set by the caller.
  task automatic send(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit m, input bit clr, input bit expect_out,
                      input logic [W-1:0] ex, input logic [W-1:0] ey);
    exp_t e;
    int   used;
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    mode     = m;
    tw_clr   = clr;
    if (expect_out) begin
      e.tag = tag; e.ex = ex; e.ey = ey; e.due = cyc + L;
      exp_q.push_back(e);
    end
    used   = clr ? 0 : tb_idx;
    tb_idx = (used == NTW - 1) ? 0 : used + 1;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic send_model(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input bit m, input bit clr);
    longint unsigned ex;
    longint unsigned ey;
    int              used;
    used = clr ? 0 : tb_idx;
    model(longint'(x), longint'(y), longint'(mirror[used]), m, ex, ey);
    send(tag, x, y, m, clr, 1'b1, W'(ex), W'(ey));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 2 * L && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; tb_idx = 0; cyc = 0;
    rst = 1'b1; x_in = '0; y_in = '0; mode = 1'b0; tw_waddr = '0; tw_wdata = '0;
    clear_inputs();
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_x", {4'd0, x_out}, 32'd0);
    check_eq("reset_y", {4'd0, y_out}, 32'd0);
    @(posedge clk);
    #1;

    // 1: basic CT with w=1
    ram_write(0, 28'd1);
    send("t1_ct", 28'd5, 28'd3, 1'b0, 1'b1, 1'b1, 28'd8, 28'd2);
    wait_drain("t1");

    // 2: add wrap and sub underflow
    send("t2_wrap", W'(QM - 1), 28'd1, 1'b0, 1'b1, 1'b1, 28'd0, W'(QM - 2));
    send("t2_under", 28'd0, 28'd1, 1'b0, 1'b1, 1'b1, 28'd1, W'(QM - 1));
    wait_drain("t2");

    // 3: GS with w=2, positive and negative difference
    ram_write(0, 28'd2);
    send("t3_gs_pos", 28'd10, 28'd4, 1'b1, 1'b1, 1'b1, 28'd14, 28'd12);
    send("t3_gs_neg", 28'd4, 28'd10, 1'b1, 1'b1, 1'b1, 28'd14, W'(QM - 12));
    // same-cycle write to the address being read: the old value 2 is used
    tw_we = 1'b1; tw_waddr = 5'd0; tw_wdata = 28'd7;
    send("t3_wr_old", 28'd0, 28'd1, 1'b0, 1'b1, 1'b1, 28'd2, W'(QM - 2));
    mirror[0] = 28'd7;
    send("t3_wr_new", 28'd0, 28'd1, 1'b0, 1'b1, 1'b1, 28'd7, W'(QM - 7));
    wait_drain("t3");

    // 4: index walk and wrap, with an idle gap
    for (int i = 0; i < NTW; i++) ram_write(i, W'(i + 1));
    tw_clr = 1'b1;
    idle(1);
    tw_clr = 1'b0;
    tb_idx = 0;
    for (int k = 0; k < NTW + 2; k++) begin
      send($sformatf("t4_s%0d", k), 28'd0, 28'd1, 1'b0, 1'b0, 1'b1,
           W'((k % NTW) + 1), W'(QM - longint'((k % NTW) + 1)));
      if (k == 10) idle(3);
    end
    wait_drain("t4");

    // 5: alternating modes on random operands and random twiddles
    for (int i = 0; i < NTW; i++) ram_write(i, W'($urandom_range(32'(QM - 1), 0)));
    send_model("t5_edge0", W'(QM - 1), W'(QM - 1), 1'b0, 1'b1);
    send_model("t5_edge1", 28'd0, W'(QM - 1), 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      send_model($sformatf("t5_s%0d", k), W'($urandom_range(32'(QM - 1), 0)),
                 W'($urandom_range(32'(QM - 1), 0)), 1'(k % 2), 1'b0);
    end
    wait_drain("t5");

    // 6: reset with samples in flight
    for (int k = 0; k < 3; k++) send("t6_drop", 28'd1, 28'd2, 1'(k % 2), 1'b0, 1'b0, 28'd0, 28'd0);
    rst = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      check_eq($sformatf("t6_flush%0d", i), {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      if (i == 1) rst = 1'b0;
    end
    check_eq("t6_rst_x", {4'd0, x_out}, 32'd0);
    tb_idx = 0;
    send_model("t6_idx0", 28'd0, 28'd1, 1'b0, 1'b0);
    send_model("t6_idx1", 28'd12345, 28'd678, 1'b1, 1'b0);
    wait_drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
